// File: rtl/lpm_demux_stream.sv
// rtl/lpm_demux_stream.sv - streaming demux: one tagged input stream steered to lpm_size valid/ready channels
// Ports: clock, aclr_n (async active-low), clken; data/sel/in_valid/in_ready input handshake;
//        result (shared head payload), result_valid (one-hot per channel), result_ready (per channel);
//        drop_count (out-of-range beat counter, live only with LPM_DEMUX_STREAM_DROP_COUNT_EN defined)
module lpm_demux_stream #(
  parameter int lpm_width  = 32,
  parameter int lpm_size   = 4,
  parameter int lpm_widths = 2
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  clken,
  input  logic [lpm_width-1:0]  data,
  input  logic [lpm_widths-1:0] sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [lpm_width-1:0]  result,
  output logic [lpm_size-1:0]   result_valid,
  input  logic [lpm_size-1:0]   result_ready,
  output logic [15:0]           drop_count
);

  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  in_ready_q, in_ready_d;
  logic [lpm_widths-1:0] sel_mem_q [2];
  logic [lpm_widths-1:0] sel_mem_d [2];
  logic [lpm_width-1:0]  data_mem_q [2];
  logic [lpm_width-1:0]  data_mem_d [2];

  logic                  not_empty;
  logic [lpm_widths-1:0] head_sel;
  logic                  head_ready;
  logic                  accept;
  logic                  in_range;
  logic                  push;
  logic                  pop;

  always_comb begin
    not_empty = (count_q != 2'd0);
    head_sel  = sel_mem_q[rd_ptr_q];
    accept    = clken && in_valid && in_ready_q;
    in_range  = (int'(sel) < lpm_size);
    push      = accept && in_range;

    // Only the head's own channel may pop it; other channels' ready is ignored.
    head_ready = 1'b0;
    for (int k = 0; k < lpm_size; k++) begin
      head_ready = head_ready | (result_ready[k] && (int'(head_sel) == k));
    end
    pop = clken && not_empty && head_ready;

    count_d  = count_q + 2'(push) - 2'(pop);
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    // Hold in_ready_q while disabled so it first rises on an enabled edge after reset.
    in_ready_d = clken ? (count_d != 2'd2) : in_ready_q;

    sel_mem_d  = sel_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      sel_mem_d[wr_ptr_q]  = sel;
      data_mem_d[wr_ptr_q] = data;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
      sel_mem_q  <= '{default: '0};
      data_mem_q <= '{default: '0};
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
      sel_mem_q  <= sel_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

  // Outputs derive from state only (plus the clken gate), so result holds while clken is low.
  always_comb begin
    in_ready = in_ready_q && clken;
    result   = not_empty ? data_mem_q[rd_ptr_q] : '0;
    for (int k = 0; k < lpm_size; k++) begin
      result_valid[k] = clken && not_empty && (int'(head_sel) == k);
    end
  end

`ifdef LPM_DEMUX_STREAM_DROP_COUNT_EN
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (accept && !in_range && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      drop_count_q <= 16'd0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_lpm_demux_stream.sv
// tb/tb_lpm_demux_stream.sv - self-checking bench for lpm_demux_stream
module tb_lpm_demux_stream;

  logic        clk;
  logic        aclr_n;
  logic        clken;
  logic [31:0] data;
  logic [1:0]  sel;

  logic        iv4, ir4;
  logic [31:0] res4;
  logic [3:0]  rv4, rr4;
  logic [15:0] dc4;

  logic        iv3, ir3;
  logic [31:0] res3;
  logic [2:0]  rv3, rr3;
  logic [15:0] dc3;

  int errors = 0;
  int checks = 0;

  lpm_demux_stream dut4 (
    .clock(clk), .aclr_n(aclr_n), .clken(clken), .data(data), .sel(sel),
    .in_valid(iv4), .in_ready(ir4), .result(res4), .result_valid(rv4),
    .result_ready(rr4), .drop_count(dc4)
  );

  lpm_demux_stream #(.lpm_width(32), .lpm_size(3), .lpm_widths(2)) dut3 (
    .clock(clk), .aclr_n(aclr_n), .clken(clken), .data(data), .sel(sel),
    .in_valid(iv3), .in_ready(ir3), .result(res3), .result_valid(rv3),
    .result_ready(rr3), .drop_count(dc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model for dut4: a FIFO queue of accepted beats, capacity 2.
  typedef struct {
    logic [1:0]  s;
    logic [31:0] d;
  } ent_t;
  ent_t mq[$];
  bit   ir_m = 1'b0;
  int   drop_m = 0;

  always @(negedge clk) begin
    logic [3:0]  erv;
    logic [31:0] eres;
    bit          acc, pp;
    if (!aclr_n) begin
      mq.delete();
      ir_m   = 1'b0;
      drop_m = 0;
    end
    erv  = (clken && mq.size() > 0) ? 4'(1 << mq[0].s) : 4'd0;
    eres = (mq.size() > 0) ? mq[0].d : 32'd0;
    chk("m_in_ready", {31'd0, ir4}, {31'd0, clken && ir_m});
    chk("m_result_valid", {28'd0, rv4}, {28'd0, erv});
    chk("m_result", res4, eres);
    chk("m_drop_count", {16'd0, dc4}, 32'(drop_m));
    if (aclr_n) begin
      acc = clken && iv4 && ir_m;
      pp  = clken && mq.size() > 0 && rr4[mq[0].s];
      if (pp) void'(mq.pop_front());
      if (acc) begin
        if (int'(sel) < 4) mq.push_back('{sel, data});
        else if (drop_m < 65535) drop_m++;
      end
      if (clken) ir_m = (mq.size() < 2);
    end
  end

  typedef struct {
    logic        ce;
    logic        iv;
    logic [1:0]  s;
    logic [31:0] d;
    logic [3:0]  rr;
    logic        exp_ir;
    logic [3:0]  exp_rv;
    logic [31:0] exp_res;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] got3[$];
    logic [1:0]  s3[7];
    int          exp_dc;

    aclr_n = 1'b1; clken = 1'b1; data = '0; sel = '0;
    iv4 = 1'b0; rr4 = '0; iv3 = 1'b0; rr3 = '0;
    #2 aclr_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {31'd0, ir4}, 32'd0);
    chk("rst_result_valid", {28'd0, rv4}, 32'd0);
    chk("rst_result", res4, 32'd0);
    chk("rst_drop_count", {16'd0, dc4}, 32'd0);
    cyc(); aclr_n = 1'b1;
    @(negedge clk);
    chk("in_ready_before_first_edge", {31'd0, ir4}, 32'd0);
    cyc();
    @(negedge clk);
    chk("in_ready_after_first_edge", {31'd0, ir4}, 32'd1);

    // Single beat, then full/backpressure with non-head ready ignored
    tbl[0]  = '{1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 4'b1111, 1'b1, 4'b0000, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 32'h0,        4'b1111, 1'b1, 4'b0100, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 32'h0,        4'b1111, 1'b1, 4'b0000, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 2'd0, 32'h11,       4'b0000, 1'b1, 4'b0000, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 2'd3, 32'h22,       4'b0000, 1'b1, 4'b0001, 32'h11};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 32'h0,        4'b1110, 1'b0, 4'b0001, 32'h11};
    tbl[6]  = '{1'b1, 1'b1, 2'd1, 32'h33,       4'b0001, 1'b0, 4'b0001, 32'h11};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 32'h0,        4'b0111, 1'b1, 4'b1000, 32'h22};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 32'h0,        4'b1000, 1'b1, 4'b1000, 32'h22};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 32'h0,        4'b0000, 1'b1, 4'b0000, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 2'd1, 32'h44,       4'b1111, 1'b0, 4'b0000, 32'h0};
    for (int i = 0; i < 11; i++) begin
      cyc();
      clken = tbl[i].ce; iv4 = tbl[i].iv; sel = tbl[i].s; data = tbl[i].d; rr4 = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, ir4}, {31'd0, tbl[i].exp_ir});
      chk($sformatf("tbl%0d_result_valid", i), {28'd0, rv4}, {28'd0, tbl[i].exp_rv});
      chk($sformatf("tbl%0d_result", i), res4, tbl[i].exp_res);
    end
    cyc(); clken = 1'b1; iv4 = 1'b0;
    @(negedge clk);
    chk("idle_empty", {28'd0, rv4}, 32'd0);

    // Reset mid-stream: two beats queued, then lost
    cyc(); iv4 = 1'b1; sel = 2'd1; data = 32'hA1; rr4 = 4'b0000;
    cyc(); data = 32'hA2;
    cyc(); iv4 = 1'b0; aclr_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, ir4}, 32'd0);
    chk("midrst_result_valid", {28'd0, rv4}, 32'd0);
    cyc(); aclr_n = 1'b1; rr4 = 4'b1111;
    @(negedge clk);
    chk("midrst_release_in_ready", {31'd0, ir4}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("postrst_in_ready", {31'd0, ir4}, 32'd1);
      chk("postrst_no_beats", {28'd0, rv4}, 32'd0);
    end

    // clken hold: head pending on channel 2
    cyc(); iv4 = 1'b1; sel = 2'd2; data = 32'hC1; rr4 = 4'b0000;
    cyc(); iv4 = 1'b0; clken = 1'b0; rr4 = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clkoff_result_valid", {28'd0, rv4}, 32'd0);
      chk("clkoff_in_ready", {31'd0, ir4}, 32'd0);
      chk("clkoff_result_hold", res4, 32'hC1);
      if (i < 2) cyc();
    end
    cyc(); clken = 1'b1;
    @(negedge clk);
    chk("clkon_result_valid", {28'd0, rv4}, 32'b0100);
    chk("clkon_result", res4, 32'hC1);
    cyc();
    @(negedge clk);
    chk("clkon_popped_once", {28'd0, rv4}, 32'd0);

    // Throughput: 8 back-to-back beats
    rr4 = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      cyc();
      if (k < 8) begin iv4 = 1'b1; sel = 2'(k % 4); data = 32'h100 + 32'(k); end
      else iv4 = 1'b0;
      @(negedge clk);
      chk("tput_in_ready", {31'd0, ir4}, 32'd1);
      if (k > 0) begin
        chk("tput_result_valid", {28'd0, rv4}, 32'(1 << ((k - 1) % 4)));
        chk("tput_result", res4, 32'h100 + 32'(k - 1));
      end
    end

    // Out-of-range on lpm_size=3 instance
    iv4 = 1'b0; rr3 = 3'b111;
    s3[0] = 2'd3; s3[1] = 2'd1; s3[2] = 2'd3; s3[3] = 2'd3;
    s3[4] = 2'd1; s3[5] = 2'd3; s3[6] = 2'd3;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c < 7) begin iv3 = 1'b1; sel = s3[c]; data = 32'h300 + 32'(c); end
      else iv3 = 1'b0;
      @(negedge clk);
      chk("oor_in_ready", {31'd0, ir3}, 32'd1);
      if (rv3 == 3'b010) got3.push_back(res3);
      else if (rv3 != 3'b000) chk("oor_bad_channel", {29'd0, rv3}, 32'b010);
    end
    chk("oor_beat_count", 32'(got3.size()), 32'd2);
    if (got3.size() == 2) begin
      chk("oor_beat0", got3[0], 32'h301);
      chk("oor_beat1", got3[1], 32'h304);
    end
`ifdef LPM_DEMUX_STREAM_DROP_COUNT_EN
    exp_dc = 5;
`else
    exp_dc = 0;
`endif
    chk("oor_drop_count", {16'd0, dc3}, 32'(exp_dc));

    // Randomized stimulus against the queue model
    for (int n = 0; n < 3000; n++) begin
      cyc();
      aclr_n = ($urandom_range(0, 399) != 0);
      clken  = ($urandom_range(0, 7) != 0);
      iv4    = ($urandom_range(0, 3) != 0);
      sel    = 2'($urandom_range(0, 3));
      data   = $urandom;
      rr4    = 4'($urandom_range(0, 15));
    end
    cyc(); aclr_n = 1'b1; clken = 1'b1; iv4 = 1'b0; rr4 = 4'b1111;
    repeat (4) cyc();
    @(negedge clk);
    chk("drain_empty", {28'd0, rv4}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
